// File: rtl/axis_fft_ifft_8point.sv
// 8-point radix-2 DIT FFT/IFFT on AXI4-Stream: one full complex frame per beat,
// four register stages with a single shared enable driven by output backpressure.
module axis_fft_ifft_8point #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 32,
  parameter int TWID_W    = 16,
  parameter int SCALE_INV = 1
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [16*DATA_W-1:0]  s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [16*OUT_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [31:0]           frame_count
);
  localparam int W1 = DATA_W + 1;
  localparam int W2 = DATA_W + 2;
  localparam int W3 = DATA_W + 4;
  localparam int PW = W2 + TWID_W + 2;
  localparam int TWC_I = int'(0.70710678 * (2.0 ** (TWID_W - 1)));
  localparam logic signed [TWID_W:0] TWC = TWC_I[TWID_W:0];

  logic ce;
  assign ce = m_axis_tready | ~m_axis_tvalid;
  assign s_axis_tready = ce;

  // (+/-a*C +/- b*C) at full width, then floor-shifted back to sample scale
  function automatic logic signed [W3-1:0] tw_prod(input logic signed [W2-1:0] a,
                                                   input logic signed [W2-1:0] b,
                                                   input logic neg_a, input logic neg_b);
    logic signed [PW-1:0] pa, pb, sum;
    pa = PW'(a) * PW'(TWC);
    pb = PW'(b) * PW'(TWC);
    if (neg_a) pa = -pa;
    if (neg_b) pb = -pb;
    sum = pa + pb;
    sum = sum >>> (TWID_W - 1);
    return sum[W3-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] out_scale(input logic signed [W3-1:0] x,
                                                        input logic inv);
    logic signed [W3-1:0] y;
    y = (inv && SCALE_INV != 0) ? (x >>> 3) : x;
    return OUT_W'(y);
  endfunction

  logic signed [DATA_W-1:0] xr_p0 [8];
  logic signed [DATA_W-1:0] xi_p0 [8];
  logic                     vld_p0, inv_p0, last_p0;
  logic signed [W1-1:0]     ur_p1 [8];
  logic signed [W1-1:0]     ui_p1 [8];
  logic                     vld_p1, inv_p1, last_p1;
  logic signed [W2-1:0]     qr_p2 [8];
  logic signed [W2-1:0]     qi_p2 [8];
  logic                     vld_p2, inv_p2, last_p2;
  logic signed [W3-1:0]     wr [4];
  logic signed [W3-1:0]     wi [4];
  logic signed [OUT_W-1:0]  yr [8];
  logic signed [OUT_W-1:0]  yi [8];

  // S0: capture the input frame
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      vld_p0 <= 1'b0; inv_p0 <= 1'b0; last_p0 <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        xr_p0[n] <= '0; xi_p0[n] <= '0;
      end
    end else if (ce) begin
      vld_p0  <= s_axis_tvalid;
      inv_p0  <= s_axis_tuser;
      last_p0 <= s_axis_tlast;
      for (int n = 0; n < 8; n++) begin
        xr_p0[n] <= s_axis_tdata[n*2*DATA_W + DATA_W +: DATA_W];
        xi_p0[n] <= s_axis_tdata[n*2*DATA_W +: DATA_W];
      end
    end
  end

  // S1: 2-point butterflies; group g pairs sample bitrev2(g) with bitrev2(g)+4
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      vld_p1 <= 1'b0; inv_p1 <= 1'b0; last_p1 <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        ur_p1[n] <= '0; ui_p1[n] <= '0;
      end
    end else if (ce) begin
      vld_p1  <= vld_p0;
      inv_p1  <= inv_p0;
      last_p1 <= last_p0;
      for (int g = 0; g < 4; g++) begin
        ur_p1[2*g]   <= W1'(xr_p0[2*(g%2)+g/2]) + W1'(xr_p0[2*(g%2)+g/2+4]);
        ui_p1[2*g]   <= W1'(xi_p0[2*(g%2)+g/2]) + W1'(xi_p0[2*(g%2)+g/2+4]);
        ur_p1[2*g+1] <= W1'(xr_p0[2*(g%2)+g/2]) - W1'(xr_p0[2*(g%2)+g/2+4]);
        ui_p1[2*g+1] <= W1'(xi_p0[2*(g%2)+g/2]) - W1'(xi_p0[2*(g%2)+g/2+4]);
      end
    end
  end

  // S2: 4-point combine; slots 0..3 hold the even half, 4..7 the odd half
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      vld_p2 <= 1'b0; inv_p2 <= 1'b0; last_p2 <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        qr_p2[n] <= '0; qi_p2[n] <= '0;
      end
    end else if (ce) begin
      vld_p2  <= vld_p1;
      inv_p2  <= inv_p1;
      last_p2 <= last_p1;
      for (int h = 0; h < 2; h++) begin
        qr_p2[4*h]   <= W2'(ur_p1[4*h]) + W2'(ur_p1[4*h+2]);
        qi_p2[4*h]   <= W2'(ui_p1[4*h]) + W2'(ui_p1[4*h+2]);
        qr_p2[4*h+2] <= W2'(ur_p1[4*h]) - W2'(ur_p1[4*h+2]);
        qi_p2[4*h+2] <= W2'(ui_p1[4*h]) - W2'(ui_p1[4*h+2]);
        qr_p2[4*h+1] <= inv_p1 ? W2'(ur_p1[4*h+1]) - W2'(ui_p1[4*h+3])
                               : W2'(ur_p1[4*h+1]) + W2'(ui_p1[4*h+3]);
        qi_p2[4*h+1] <= inv_p1 ? W2'(ui_p1[4*h+1]) + W2'(ur_p1[4*h+3])
                               : W2'(ui_p1[4*h+1]) - W2'(ur_p1[4*h+3]);
        qr_p2[4*h+3] <= inv_p1 ? W2'(ur_p1[4*h+1]) + W2'(ui_p1[4*h+3])
                               : W2'(ur_p1[4*h+1]) - W2'(ui_p1[4*h+3]);
        qi_p2[4*h+3] <= inv_p1 ? W2'(ui_p1[4*h+1]) - W2'(ur_p1[4*h+3])
                               : W2'(ui_p1[4*h+1]) + W2'(ur_p1[4*h+3]);
      end
    end
  end

  // Odd half times W8^k (conjugated for inverse); k=2 is an exact swap/negate
  always_comb begin
    wr[0] = W3'(qr_p2[4]);
    wi[0] = W3'(qi_p2[4]);
    wr[1] = tw_prod(qr_p2[5], qi_p2[5], 1'b0, inv_p2);
    wi[1] = tw_prod(qr_p2[5], qi_p2[5], ~inv_p2, 1'b0);
    wr[2] = inv_p2 ? -W3'(qi_p2[6]) : W3'(qi_p2[6]);
    wi[2] = inv_p2 ? W3'(qr_p2[6]) : -W3'(qr_p2[6]);
    wr[3] = tw_prod(qr_p2[7], qi_p2[7], 1'b1, inv_p2);
    wi[3] = tw_prod(qr_p2[7], qi_p2[7], ~inv_p2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      yr[k]   = out_scale(W3'(qr_p2[k]) + wr[k], inv_p2);
      yi[k]   = out_scale(W3'(qi_p2[k]) + wi[k], inv_p2);
      yr[k+4] = out_scale(W3'(qr_p2[k]) - wr[k], inv_p2);
      yi[k+4] = out_scale(W3'(qi_p2[k]) - wi[k], inv_p2);
    end
  end

  // S3: output register
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (ce) begin
      m_axis_tvalid <= vld_p2;
      m_axis_tuser  <= inv_p2;
      m_axis_tlast  <= last_p2;
      for (int k = 0; k < 8; k++) begin
        m_axis_tdata[k*2*OUT_W + OUT_W +: OUT_W] <= yr[k];
        m_axis_tdata[k*2*OUT_W +: OUT_W]         <= yi[k];
      end
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset)
      frame_count <= 32'd0;
    else if (m_axis_tvalid && m_axis_tready)
      frame_count <= frame_count + 32'd1;
  end

endmodule

// File: tb/tb_axis_fft_ifft_8point.sv
// Scoreboard bench for axis_fft_ifft_8point: stimulus pushes model results,
// an independent monitor pops and compares on every output handshake.
module tb_axis_fft_ifft_8point;
  localparam int DW = 8;
  localparam int OW = 32;
  localparam longint C_TW = 23170;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [16*DW-1:0]   s_axis_tdata;
  logic               m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic [16*OW-1:0]   m_axis_tdata;
  logic [31:0]        frame_count;

  always #5 clk = ~clk;

  axis_fft_ifft_8point #(.DATA_W(DW), .OUT_W(OW), .TWID_W(16), .SCALE_INV(1)) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .frame_count(frame_count)
  );

  typedef struct { logic [16*OW-1:0] data; logic user; logic last; } exp_t;
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  bit   hold_rdy = 0;
  bit   rand_rdy = 0;

  task automatic chk(input string name, input logic [16*OW-1:0] act, input logic [16*OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Textbook iterative DIT FFT on a bit-reversed copy, twiddles as exact
  // multiples of 2^15 (or +/-C for the odd eighths) with floor after each product.
  function automatic logic [16*OW-1:0] ref_fft(input logic [16*DW-1:0] din, input logic inv);
    longint re [8], im [8];
    longint cr, ci, tr, ti;
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic signed [DW-1:0] s;
    logic [OW-1:0] o;
    logic [16*OW-1:0] res;
    for (int n = 0; n < 8; n++) begin
      s = din[br[n]*2*DW + DW +: DW]; re[n] = s;
      s = din[br[n]*2*DW +: DW];      im[n] = s;
    end
    for (int len = 2; len <= 8; len *= 2)
      for (int st = 0; st < 8; st += len)
        for (int j = 0; j < len/2; j++) begin
          case (j * (8/len))
            0: begin cr = 32768; ci = 0;      end
            1: begin cr = C_TW;  ci = -C_TW;  end
            2: begin cr = 0;     ci = -32768; end
            default: begin cr = -C_TW; ci = -C_TW; end
          endcase
          if (inv) ci = -ci;
          tr = (re[st+j+len/2]*cr - im[st+j+len/2]*ci) >>> 15;
          ti = (re[st+j+len/2]*ci + im[st+j+len/2]*cr) >>> 15;
          re[st+j+len/2] = re[st+j] - tr;
          im[st+j+len/2] = im[st+j] - ti;
          re[st+j] = re[st+j] + tr;
          im[st+j] = im[st+j] + ti;
        end
    res = '0;
    for (int k = 0; k < 8; k++) begin
      if (inv) begin re[k] = re[k] >>> 3; im[k] = im[k] >>> 3; end
      o = re[k][OW-1:0]; res[k*2*OW + OW +: OW] = o;
      o = im[k][OW-1:0]; res[k*2*OW +: OW] = o;
    end
    return res;
  endfunction

  function automatic logic [16*DW-1:0] put(input logic [16*DW-1:0] f, input int n,
                                           input int re, input int im);
    logic [16*DW-1:0] r;
    r = f;
    r[n*2*DW + DW +: DW] = re[DW-1:0];
    r[n*2*DW +: DW]      = im[DW-1:0];
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [16*DW-1:0] d, input logic u, input logic l);
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        sbq.push_back('{data: ref_fft(d, u), user: u, last: l});
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: got no s_axis_tready, required acceptance within 200 cycles");
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        @(posedge clk); #1;
        chk("frame_count_total", 512'(frame_count), 512'(n_out));
        return;
      end
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got %0d pending outputs, required 0", sbq.size());
  endtask

  // Downstream ready, changed 2 time units after each rising edge
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #2;
      m_axis_tready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: the handshake seen at a falling edge completes on the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h, required no output", m_axis_tdata);
        end else begin
          e = sbq.pop_front();
          chk("tdata", m_axis_tdata, e.data);
          chk("tuser", 512'(m_axis_tuser), 512'(e.user));
          chk("tlast", 512'(m_axis_tlast), 512'(e.last));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*DW-1:0] imp0, imp1, alt, dc, neg, mix, f;
    logic [16*OW-1:0] held;
    imp0 = put('0, 0, 64, 0);
    imp1 = put('0, 1, 64, 0);
    alt = '0; dc = '0; neg = '0; mix = '0;
    for (int n = 0; n < 8; n++) begin
      alt = put(alt, n, (n % 2 == 1) ? -32 : 32, 0);
      dc  = put(dc, n, 16, 0);
      neg = put(neg, n, -128, -128);
      mix = put(mix, n, (n % 2 == 1) ? -128 : 127, (n % 2 == 1) ? 127 : -128);
    end

    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_frame_count", 512'(frame_count), 512'(0));
    chk("rst_tuser_tlast", 512'({m_axis_tuser, m_axis_tlast}), 512'(0));
    chk("rst_tready", 512'(s_axis_tready), 512'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: output valid after the third edge following acceptance
    @(posedge clk); #1;
    send(imp0, 1'b0, 1'b0);
    @(posedge clk); #1; chk("latency_c1", 512'(m_axis_tvalid), 512'(0));
    @(posedge clk); #1; chk("latency_c2", 512'(m_axis_tvalid), 512'(0));
    @(posedge clk); #1; chk("latency_c3", 512'(m_axis_tvalid), 512'(1));
    @(posedge clk); #1; chk("frame_count_one", 512'(frame_count), 512'(1));

    send(imp1, 1'b0, 1'b0);
    send(imp1, 1'b1, 1'b0);
    send(alt, 1'b0, 1'b0);
    send(dc, 1'b0, 1'b1);
    send(neg, 1'b0, 1'b0);
    send(neg, 1'b1, 1'b0);
    send(mix, 1'b0, 1'b0);
    send(mix, 1'b1, 1'b1);
    drain();

    // Backpressure: hold ready low, 3 beats, then 5 stalled cycles
    @(negedge clk); hold_rdy = 1'b1;
    @(posedge clk); #1;
    send(imp0, 1'b0, 1'b0);
    send(dc, 1'b0, 1'b0);
    send(alt, 1'b0, 1'b1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_axis_tvalid) break;
    end
    chk("bp_first_valid", 512'(m_axis_tvalid), 512'(1));
    held = m_axis_tdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tvalid_hold", 512'(m_axis_tvalid), 512'(1));
      chk("bp_tdata_hold", m_axis_tdata, held);
      chk("bp_s_tready", 512'(s_axis_tready), 512'(0));
    end
    hold_rdy = 1'b0;
    @(posedge clk); #1;
    drain();

    // Interleaved modes on the same frame
    for (int i = 0; i < 6; i++) send(imp1, 1'(i % 2), 1'b0);
    drain();

    // Reset with two beats in flight, asserted between edges
    send(imp0, 1'b0, 1'b0);
    send(dc, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    sbq.delete();
    n_out = 0;
    #1;
    chk("midrst_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("midrst_frame_count", 512'(frame_count), 512'(0));
    chk("midrst_tdata", m_axis_tdata, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_output", 512'(m_axis_tvalid), 512'(0));
    end
    @(posedge clk); #1;
    send(imp1, 1'b1, 1'b0);
    drain();

    // Randomized frames, modes, gaps and downstream stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        s_axis_tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk); #1;
      end
      f = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
